// File: rtl/exec_pkg.sv
// exec_pkg: shared constants and types for the execute stage.
//   - ALU/MUL funct codes (immediate[5:0])
//   - calcCtrl / wbCtrl bit indices
//   - forward-select encoding and the EX FSM state enum
package exec_pkg;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_MUL = 6'h18;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam int CC_REGDST   = 3;
    localparam int CC_ALUSRC   = 0;
    localparam int WB_REGWRITE = 1;

    typedef enum logic [1:0] {
        FWD_NOM   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwdSel_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } exState_e;
endpackage

// File: rtl/execute_stage_mc_if.sv
// execute_stage_mc_if: bundle of everything the EX stage talks to.
//   ID/EX side : idValid, flush, wbCtrlIn, memCtrlIn, calcCtrl, readData1/2,
//                immediate, rs, rt  (in)  /  stall (out)
//   MEM/WB side: memWbRegWrite, memWbRd, memWbData (in, forwarding source)
//   EX/MEM side: exValid, wbCtrlOut, memCtrlOut, result, writeData, rdOut (out)
// master = pipeline around the stage, slave = the EX stage itself.
interface execute_stage_mc_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
);
    logic              idValid;
    logic              flush;
    logic [1:0]        wbCtrlIn;
    logic [2:0]        memCtrlIn;
    logic [3:0]        calcCtrl;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic [DATA_W-1:0] immediate;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic              memWbRegWrite;
    logic [RA_W-1:0]   memWbRd;
    logic [DATA_W-1:0] memWbData;
    logic              stall;
    logic              exValid;
    logic [1:0]        wbCtrlOut;
    logic [2:0]        memCtrlOut;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] writeData;
    logic [RA_W-1:0]   rdOut;

    modport master (
        output idValid, flush, wbCtrlIn, memCtrlIn, calcCtrl, readData1, readData2,
               immediate, rs, rt, memWbRegWrite, memWbRd, memWbData,
        input  stall, exValid, wbCtrlOut, memCtrlOut, result, writeData, rdOut
    );

    modport slave (
        input  idValid, flush, wbCtrlIn, memCtrlIn, calcCtrl, readData1, readData2,
               immediate, rs, rt, memWbRegWrite, memWbRd, memWbData,
        output stall, exValid, wbCtrlOut, memCtrlOut, result, writeData, rdOut
    );
endinterface

// File: rtl/mul_iter.sv
// mul_iter: radix-2 shift-add multiplier, one step per negedge, DATA_W steps.
//   start   : load opA/opB, counter = DATA_W
//   abort   : drop the operation (counter -> 0)
//   busy    : counter != 0
//   last    : counter == 1 (the step finishing now is the final one)
//   product : low DATA_W bits of the accumulator after the current step, so
//             it is the full product while last is high
module mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    output logic              busy,
    output logic              last,
    output logic [DATA_W-1:0] product
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc, mcand, mplier;

    assign busy    = (cnt != '0);
    assign last    = (cnt == CNT_W'(1));
    assign product = acc + (mplier[0] ? mcand : '0);

    always_ff @(negedge clk) begin
        if (!rstN) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else if (start) begin
            cnt    <= CNT_W'(DATA_W);
            acc    <= '0;
            mcand  <= opA;
            mplier <= opB;
        end else if (busy) begin
            cnt    <= cnt - CNT_W'(1);
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
endmodule

// File: rtl/execute_stage_mc.sv
// execute_stage_mc: EX stage with forwarding, valid/flush tracking and an
// iterative multiplier; owns the EX/MEM register (updated on negedge).
//   clk, rstN : clock (negedge active), synchronous active-low reset
//   ex        : execute_stage_mc_if.slave (ID/EX inputs, MEM/WB forwarding
//               inputs, stall out, EX/MEM register outputs)
module execute_stage_mc
    import exec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int MUL_EN = 1,
    parameter int FWD_EN = 1
) (
    input logic               clk,
    input logic               rstN,
    execute_stage_mc_if.slave ex
);
    localparam int SH_W = $clog2(DATA_W);

    exState_e          state, stateNext;
    fwdSel_e           sel1, sel2;
    logic              exFwdOk, wbFwdOk;
    logic [DATA_W-1:0] fwd1, fwd2, op2, aluRes, mulProd;
    logic [5:0]        funct;
    logic [RA_W-1:0]   rdSel;
    logic              mulReq, mulStart, mulAbort, mulLast;
    logic [1:0]        mWb;
    logic [2:0]        mMem;
    logic [DATA_W-1:0] mWd;
    logic [RA_W-1:0]   mRd;
    logic              unusedAluOp;

    assign unusedAluOp = ^ex.calcCtrl[2:1];

    function automatic logic [DATA_W-1:0] fwdMux(input fwdSel_e s,
            input logic [DATA_W-1:0] nom, input logic [DATA_W-1:0] exm,
            input logic [DATA_W-1:0] mwb);
        case (s)
            FWD_EXMEM: return exm;
            FWD_MEMWB: return mwb;
            default:   return nom;
        endcase
    endfunction

    // Register 0 is never a forwarding source: writes to it are discarded.
    assign exFwdOk = (FWD_EN != 0) && ex.exValid && ex.wbCtrlOut[WB_REGWRITE] && (ex.rdOut != '0);
    assign wbFwdOk = (FWD_EN != 0) && ex.memWbRegWrite && (ex.memWbRd != '0);
    assign sel1 = (exFwdOk && ex.rdOut == ex.rs) ? FWD_EXMEM :
                  (wbFwdOk && ex.memWbRd == ex.rs) ? FWD_MEMWB : FWD_NOM;
    assign sel2 = (exFwdOk && ex.rdOut == ex.rt) ? FWD_EXMEM :
                  (wbFwdOk && ex.memWbRd == ex.rt) ? FWD_MEMWB : FWD_NOM;
    assign fwd1 = fwdMux(sel1, ex.readData1, ex.result, ex.memWbData);
    assign fwd2 = fwdMux(sel2, ex.readData2, ex.result, ex.memWbData);

    assign op2    = ex.calcCtrl[CC_ALUSRC] ? ex.immediate : fwd2;
    assign funct  = ex.immediate[5:0];
    assign rdSel  = ex.calcCtrl[CC_REGDST] ? ex.rs : ex.rt;
    assign mulReq = (MUL_EN != 0) && ex.idValid && (funct == FN_MUL) && !ex.flush;

    // MUL is not handled here: with MUL_EN=0 it falls to the unknown-funct case.
    always_comb begin
        aluRes = '0;
        case (funct)
            FN_ADD:  aluRes = fwd1 + op2;
            FN_SUB:  aluRes = fwd1 - op2;
            FN_AND:  aluRes = fwd1 & op2;
            FN_OR:   aluRes = fwd1 | op2;
            FN_XOR:  aluRes = fwd1 ^ op2;
            FN_SLT:  aluRes = {{(DATA_W-1){1'b0}}, $signed(fwd1) < $signed(op2)};
            FN_SLL:  aluRes = fwd1 << op2[SH_W-1:0];
            FN_SRL:  aluRes = fwd1 >> op2[SH_W-1:0];
            default: aluRes = '0;
        endcase
    end

    generate
        if (MUL_EN != 0) begin : gMul
            logic mulBusy;
            mul_iter #(.DATA_W(DATA_W)) uMul (
                .clk(clk), .rstN(rstN), .start(mulStart), .abort(mulAbort),
                .opA(fwd1), .opB(op2), .busy(mulBusy), .last(mulLast),
                .product(mulProd)
            );
        end else begin : gNoMul
            logic unusedMul;
            assign unusedMul = ^{mulStart, mulAbort};
            assign mulLast   = 1'b0;
            assign mulProd   = '0;
        end
    endgenerate

    // In BUSY the counter is >= 1, so "counter > 1" is simply "not last".
    always_comb begin
        stateNext = state;
        ex.stall  = 1'b0;
        mulStart  = 1'b0;
        mulAbort  = 1'b0;
        case (state)
            IDLE: begin
                if (mulReq) begin
                    ex.stall  = 1'b1;
                    mulStart  = 1'b1;
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                if (ex.flush) begin
                    mulAbort  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    ex.stall = !mulLast;
                    if (mulLast) stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // EX/MEM data is held (not cleared) across MUL bubbles; exValid=0 marks it dead.
    always_ff @(negedge clk) begin
        if (!rstN) begin
            state         <= IDLE;
            ex.exValid    <= 1'b0;
            ex.wbCtrlOut  <= '0;
            ex.memCtrlOut <= '0;
            ex.result     <= '0;
            ex.writeData  <= '0;
            ex.rdOut      <= '0;
            mWb           <= '0;
            mMem          <= '0;
            mWd           <= '0;
            mRd           <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE) begin
                if (mulReq) begin
                    ex.exValid <= 1'b0;
                    mWb        <= ex.wbCtrlIn;
                    mMem       <= ex.memCtrlIn;
                    mWd        <= fwd2;
                    mRd        <= rdSel;
                end else begin
                    ex.exValid    <= ex.idValid && !ex.flush;
                    ex.wbCtrlOut  <= ex.wbCtrlIn;
                    ex.memCtrlOut <= ex.memCtrlIn;
                    ex.result     <= aluRes;
                    ex.writeData  <= fwd2;
                    ex.rdOut      <= rdSel;
                end
            end else begin
                ex.exValid <= 1'b0;
                if (!ex.flush && mulLast) begin
                    ex.exValid    <= 1'b1;
                    ex.wbCtrlOut  <= mWb;
                    ex.memCtrlOut <= mMem;
                    ex.result     <= mulProd;
                    ex.writeData  <= mWd;
                    ex.rdOut      <= mRd;
                end
            end
        end
    end
endmodule

// File: tb/tb_execute_stage_mc.sv
// tb_execute_stage_mc: directed + random stimulus against a behavioural
// model of the EX stage (forwarding rules, ALU arithmetic, MUL as a plain
// product delivered DATA_W edges after acceptance).
module tb_execute_stage_mc;
    import exec_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    execute_stage_mc_if #(.DATA_W(DW), .RA_W(AW)) bus();

    execute_stage_mc #(.DATA_W(DW), .RA_W(AW), .MUL_EN(1), .FWD_EN(1)) dut (
        .clk(clk), .rstN(rstN), .ex(bus.slave)
    );

    int total = 0;
    int fails = 0;

    // model of the EX/MEM register and of an outstanding multiply
    logic          mValid = 1'b0;
    logic [1:0]    mWb = '0;
    logic [2:0]    mMem = '0;
    logic [DW-1:0] mRes = '0, mWd = '0;
    logic [AW-1:0] mRd = '0;
    int            mulLeft = 0;
    logic [1:0]    pWb;
    logic [2:0]    pMem;
    logic [DW-1:0] pRes, pWd;
    logic [AW-1:0] pRd;
    logic          justReset = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] fwdRef(input logic [AW-1:0] src, input logic [DW-1:0] nom);
        if (mValid && mWb[1] && mRd != 0 && mRd == src) return mRes;
        if (bus.memWbRegWrite && bus.memWbRd != 0 && bus.memWbRd == src) return bus.memWbData;
        return nom;
    endfunction

    function automatic logic [DW-1:0] aluRef(input logic [5:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (f)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h2A: return ($signed(a) < $signed(b)) ? 1 : 0;
            6'h00: return a << (b % DW);
            6'h02: return a >> (b % DW);
            default: return 0;
        endcase
    endfunction

    function automatic logic expStall();
        if (mulLeft > 0) return (mulLeft > 1) && !bus.flush;
        return bus.idValid && bus.immediate[5:0] == 6'h18 && !bus.flush;
    endfunction

    task automatic modelEdge();
        logic [DW-1:0] a, b, o2;
        logic [5:0] f;
        justReset = !rstN;
        if (!rstN) begin
            mValid = 0; mWb = 0; mMem = 0; mRes = 0; mWd = 0; mRd = 0; mulLeft = 0;
        end else if (mulLeft > 0) begin
            mValid = 0;
            if (bus.flush) mulLeft = 0;
            else begin
                mulLeft--;
                if (mulLeft == 0) begin
                    mValid = 1; mWb = pWb; mMem = pMem; mRes = pRes; mWd = pWd; mRd = pRd;
                end
            end
        end else begin
            a  = fwdRef(bus.rs, bus.readData1);
            b  = fwdRef(bus.rt, bus.readData2);
            o2 = bus.calcCtrl[0] ? bus.immediate : b;
            f  = bus.immediate[5:0];
            if (bus.idValid && !bus.flush && f == 6'h18) begin
                mulLeft = DW; mValid = 0;
                pRes = a * o2; pWb = bus.wbCtrlIn; pMem = bus.memCtrlIn; pWd = b;
                pRd = bus.calcCtrl[3] ? bus.rs : bus.rt;
            end else begin
                mValid = bus.idValid && !bus.flush;
                mWb = bus.wbCtrlIn; mMem = bus.memCtrlIn; mRes = aluRef(f, a, o2); mWd = b;
                mRd = bus.calcCtrl[3] ? bus.rs : bus.rt;
            end
        end
    endtask

    // One clock: check stall against current inputs, take the negedge, check EX/MEM.
    task automatic cycle();
        #1;
        chk("stall", bus.stall, expStall());
        @(negedge clk);
        modelEdge();
        #2;
        chk("exValid", bus.exValid, mValid);
        if (mValid || justReset) begin
            chk("wbCtrlOut", bus.wbCtrlOut, mWb);
            chk("memCtrlOut", bus.memCtrlOut, mMem);
            chk("result", bus.result, mRes);
            chk("writeData", bus.writeData, mWd);
            chk("rdOut", bus.rdOut, mRd);
        end
    endtask

    task automatic issue(input logic v, input logic [5:0] fn, input logic [AW-1:0] s, input logic [AW-1:0] t,
                         input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [3:0] cc,
                         input logic [1:0] wb);
        bus.idValid = v; bus.rs = s; bus.rt = t; bus.readData1 = d1; bus.readData2 = d2;
        bus.calcCtrl = cc; bus.wbCtrlIn = wb; bus.memCtrlIn = 3'b101;
        bus.immediate = {26'h0, fn};
    endtask

    task automatic setWb(input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        bus.memWbRegWrite = we; bus.memWbRd = rd; bus.memWbData = d;
    endtask

    logic [5:0] fnTab [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02, 6'h18, 6'h3F};

    initial begin
        int stallCnt;
        bus.flush = 0;
        issue(0, 6'h20, 0, 0, 0, 0, 4'h0, 2'b00);
        setWb(0, 0, 0);
        @(negedge clk); #2;

        // reset
        cycle();
        chk("rst_exValid", bus.exValid, 0);
        chk("rst_result", bus.result, 0);
        rstN = 1;

        // EX/MEM beats MEM/WB
        issue(1, 6'h20, 1, 3, 2, 3, 4'h0, 2'b10); cycle();
        chk("A_result", bus.result, 5);
        setWb(1, 3, 9);
        issue(1, 6'h20, 3, 4, 100, 1, 4'h0, 2'b10); cycle();
        chk("fwdPriority", bus.result, 6);

        // register 0 never forwards
        setWb(0, 0, 0);
        issue(1, 6'h20, 5, 0, 7, 0, 4'h0, 2'b10); cycle();
        chk("rd0_rdOut", bus.rdOut, 0);
        setWb(1, 0, 7);
        issue(1, 6'h20, 0, 2, 0, 11, 4'h0, 2'b00); cycle();
        chk("rd0_noFwd", bus.result, 11);

        // MUL 7x6
        setWb(0, 0, 0);
        issue(1, 6'h18, 1, 2, 7, 6, 4'h0, 2'b10); cycle();
        chk("mulAccept_exValid", bus.exValid, 0);
        issue(1, 6'h20, 5, 6, 10, 20, 4'h0, 2'b00);
        stallCnt = 0;
        for (int k = 1; k <= DW; k++) begin
            #1;
            if (bus.stall) stallCnt++;
            cycle();
            if (k < DW) chk("mulBubble", bus.exValid, 0);
        end
        chk("mulStallCnt", stallCnt, DW - 1);
        chk("mulResult", bus.result, 42);
        chk("mulValid", bus.exValid, 1);
        cycle();
        chk("heldAdd", bus.result, 30);

        // SUB / SLT / SRL
        issue(1, 6'h22, 7, 8, 0, 1, 4'h0, 2'b00); cycle();
        chk("sub", bus.result, 32'hFFFF_FFFF);
        issue(1, 6'h2A, 7, 8, 32'hFFFF_FFFF, 1, 4'h0, 2'b00); cycle();
        chk("slt", bus.result, 1);
        issue(1, 6'h02, 7, 8, 32'h8000_0000, 31, 4'h0, 2'b00); cycle();
        chk("srl", bus.result, 1);

        // flush at BUSY cycle 10
        issue(1, 6'h18, 7, 8, 5, 5, 4'h0, 2'b10); cycle();
        bus.idValid = 0;
        for (int k = 1; k <= 9; k++) cycle();
        bus.flush = 1;
        #1;
        chk("flushStall", bus.stall, 0);
        cycle();
        chk("flushValid", bus.exValid, 0);
        bus.flush = 0;
        issue(1, 6'h20, 9, 10, 2, 3, 4'h0, 2'b00); cycle();
        chk("postFlushValid", bus.exValid, 1);
        chk("postFlushResult", bus.result, 5);

        // reset mid-MUL
        issue(1, 6'h18, 9, 10, 4, 4, 4'h0, 2'b10); cycle();
        bus.idValid = 0;
        for (int k = 0; k < 5; k++) cycle();
        rstN = 0; cycle();
        chk("midRst_exValid", bus.exValid, 0);
        chk("midRst_wb", bus.wbCtrlOut, 0);
        chk("midRst_mem", bus.memCtrlOut, 0);
        chk("midRst_result", bus.result, 0);
        chk("midRst_wd", bus.writeData, 0);
        chk("midRst_rd", bus.rdOut, 0);
        rstN = 1;
        issue(1, 6'h18, 11, 12, 3, 3, 4'h0, 2'b10); cycle();
        bus.idValid = 0;
        for (int k = 0; k < DW; k++) cycle();
        chk("mul3x3", bus.result, 9);
        chk("mul3x3_valid", bus.exValid, 1);

        // random
        for (int i = 0; i < 400; i++) begin
            logic [5:0] fn;
            fn = ($urandom_range(0, 15) == 0) ? 6'h18 : fnTab[$urandom_range(0, 9)];
            if (fn == 6'h18 && $urandom_range(0, 1) == 0) fn = 6'h20;
            bus.idValid   = ($urandom_range(0, 4) != 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            rstN          = ($urandom_range(0, 99) != 0);
            bus.rs        = AW'($urandom_range(0, 3));
            bus.rt        = AW'($urandom_range(0, 3));
            bus.readData1 = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 20)) : $urandom;
            bus.readData2 = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 40)) : $urandom;
            bus.immediate = {$urandom_range(0, 1) == 0 ? 26'h0 : 26'($urandom), fn};
            bus.calcCtrl  = 4'($urandom);
            bus.wbCtrlIn  = 2'($urandom);
            bus.memCtrlIn = 3'($urandom);
            setWb(1'($urandom), AW'($urandom_range(0, 3)), $urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/execute_stage_mc.md
Name: execute_stage_mc

Overview:
- Parametrised EX stage of the 5-stage pipeline. It sits between the ID/EX and EX/MEM registers and owns the EX/MEM register.
- Adds four things to the single-cycle EX stage:
  - width and register-address parameters;
  - valid/flush tracking;
  - register-0-aware two-level forwarding;
  - an iterative multi-cycle multiplier that stalls upstream through a stall handshake.

Parameters:
- DATA_W, 32: datapath width (min 8).
- RA_W, 5: register address width.
- MUL_EN, 1: 1 builds the iterative multiplier; 0 makes MUL an unknown funct.
- FWD_EN, 1: 1 enables forwarding; 0 always uses the nominal operands.

Ports:
- clk  in  1  pipeline clock; all state updates on negedge.
- rstN  in  1  synchronous, active-low reset.
- idValid  in  1  ID/EX holds a real instruction.
- flush  in  1  kill the instruction in EX (branch/exception).
- wbCtrlIn  in  2  write-back control; [1] = regWrite.
- memCtrlIn  in  3  memory-access control, passed through.
- calcCtrl  in  4  [3] regDst, [2:1] aluOp (passed through, unused), [0] aluSrc.
- readData1, readData2  in  DATA_W  register file operands.
- immediate  in  DATA_W  sign-extended immediate; immediate[5:0] = funct.
- rs, rt  in  RA_W  source register numbers.
- memWbRegWrite  in  1  MEM/WB write enable.
- memWbRd  in  RA_W  MEM/WB destination register.
- memWbData  in  DATA_W  MEM/WB write data.
- stall  out  1  EX busy; upstream must hold ID/EX contents.
- exValid  out  1  EX/MEM holds a real instruction.
- wbCtrlOut  out  2  registered write-back control.
- memCtrlOut  out  3  registered memory-access control.
- result  out  DATA_W  registered ALU/MUL result.
- writeData  out  DATA_W  registered forwarded rt data.
- rdOut  out  RA_W  registered destination register.

Behaviour:
- Reset (rstN=0 at a negedge):
  - all outputs 0;
  - FSM to IDLE;
  - multiplier counter 0;
  - reset overrides flush and any in-progress MUL.
- Forwarding, per operand, highest priority first:
  1. EX/MEM: exValid & wbCtrlOut[1] & rdOut!=0 & rdOut==src → result.
  2. MEM/WB: memWbRegWrite & memWbRd!=0 & memWbRd==src → memWbData.
  3. Otherwise the nominal readData.
  - FWD_EN=0 always selects nominal.
- Operand 2 = aluSrc ? immediate : forwarded rt. writeData is always the forwarded rt.
- ALU funct codes (combinational, DATA_W-bit wrap-around):
  - 0x20 ADD; 0x22 SUB; 0x24 AND; 0x25 OR; 0x26 XOR;
  - 0x2A SLT (signed, result 0/1);
  - 0x00 SLL and 0x02 SRL, shift amount = op2[log2(DATA_W)-1:0], shifted operand = op1;
  - 0x18 MUL (low DATA_W bits of the product);
  - any other funct → result 0.
- rdOut = regDst ? rs : rt.
- FSM states: IDLE, BUSY.
- IDLE, single-cycle op:
  - one negedge latency;
  - EX/MEM loads wbCtrl, memCtrl, result, writeData, rdOut;
  - exValid = idValid & ~flush.
- IDLE, idValid & MUL & MUL_EN & ~flush:
  - stall=1 combinationally;
  - at the negedge, capture forwarded op1 and op2 plus all controls/rd into the multiplier;
  - counter = DATA_W; go to BUSY;
  - exValid=0 (bubble).
- BUSY:
  - one shift-add step per negedge;
  - stall = (counter > 1); exValid=0 while counter > 1;
  - at the edge where counter==1: EX/MEM loads the product and captured controls, exValid=1, go to IDLE.
  - Total MUL latency: DATA_W negedges from acceptance to result; stall high for DATA_W-1 of them.
  - The upstream instruction held during BUSY is re-presented and is accepted at the first IDLE negedge.
- flush:
  - in IDLE, the next EX/MEM gets exValid=0 (data don't-care);
  - in BUSY, abort to IDLE, counter 0, exValid=0, stall deasserts combinationally.
- Non-MUL instructions while BUSY are not possible: stall holds them.
- stall depends only on state, counter, idValid, funct and flush.

Decomposition:
- Package exec_pkg:
  - funct constants;
  - calcCtrl bit indices;
  - forward-select encoding (NOM=00, MEMWB=01, EXMEM=10);
  - FSM state enum.
- Sub-module mul_iter:
  - radix-2 shift-add multiplier;
  - ports start, opA, opB, busy, last, product;
  - parametrised by DATA_W.
- Forward-select logic stays inline.

Test Plan:
- ADD with both EX/MEM and MEM/WB matching rs=3: EX/MEM result 5, memWbData 9, rt data 1 → result 6 (EX/MEM priority).
- rdOut=0 with regWrite, rs=0, readData1=0, memWbData 7 → no forward; result = rt data.
- MUL 7×6, DATA_W=32 → stall high 31 negedges; result 42 with exValid=1 on the 32nd; exValid 0 in between.
- SUB 0−1 → 0xFFFFFFFF. SLT −1 < 1 → 1. SRL 0x80000000 by 31 → 1.
- flush at BUSY cycle 10 → stall drops immediately, next exValid=0, FSM back in IDLE, following ADD completes in 1 cycle.
- rstN=0 mid-MUL → all outputs 0 at the next negedge; subsequent MUL 3×3=9 completes normally.
